// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline sequencer: register-index type and controller states.
package pipeline_stall_ctrl_pkg;

  localparam int REG_BITS = 5;

  typedef logic [REG_BITS-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use.sv
// Load-use hazard detect: the ID_EX load writes a register the IF_ID instruction reads.
// Purely combinational; register 0 never creates a dependency.
module load_use_detect
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int REG_W = REG_BITS
) (
  input  logic             memtoreg_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rt_id,
  output logic             lu
);

  always_comb begin
    lu = memtoreg_ex && (rd_ex != '0) &&
         ((rd_ex == rs_id) || (uses_rt_id && (rd_ex == rt_id)));
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the four pipeline latches of the 5-stage core.
// Mealy outputs from state + current inputs; data access has priority on the shared memory port.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int REG_W = REG_BITS,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_mem,
  input  logic             halt_mem,
  input  logic             memtoreg_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rt_id,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             iREN,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_state_t state;
  logic        lu;
  logic        adv;
  logic        hold;
  logic        stall_inc;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .memtoreg_ex (memtoreg_ex),
    .rd_ex       (rd_ex),
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .uses_rt_id  (uses_rt_id),
    .lu          (lu)
  );

  always_comb begin
    adv        = 1'b0;
    hold       = 1'b0;
    stall_inc  = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    iREN       = 1'b0;
    halted     = 1'b0;
    if (!RST) begin
      unique case (state)
        RUN:     adv = dmem_req_mem ? dhit : ihit;
        DWAIT:   adv = dhit;
        default: adv = 1'b0;
      endcase
      // A taken branch squashes the load-use consumer, so there is nothing to hold.
      hold       = lu && !branch_taken;
      pc_en      = adv && !hold;
      ifid_en    = adv && !hold;
      idex_en    = adv;
      exmem_en   = adv;
      memwb_en   = adv;
      ifid_flush = adv && branch_taken;
      idex_flush = adv && (branch_taken || lu);
      iREN       = (state == RUN) && !dmem_req_mem;
      halted     = (state == HALT);
      stall_inc  = (state != HALT) && (!adv || hold);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      stall_count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_mem && adv)             state <= HALT;
          else if (dmem_req_mem && !dhit)  state <= DWAIT;
        end
        DWAIT: begin
          if (halt_mem && adv)             state <= HALT;
          else if (dhit)                   state <= RUN;
        end
        default:                           state <= HALT;
      endcase
      if (stall_inc && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: driver pushes model predictions, a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST, ihit, dhit, dmem_req_mem, halt_mem, memtoreg_ex, uses_rt_id, branch_taken;
  logic [4:0]    rd_ex, rs_id, rt_id;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, iREN, halted;
  logic [CW-1:0] stall_count;

  always #5 CLK = ~CLK;

  pipeline_stall_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req_mem(dmem_req_mem),
    .halt_mem(halt_mem), .memtoreg_ex(memtoreg_ex), .rd_ex(rd_ex), .rs_id(rs_id),
    .rt_id(rt_id), .uses_rt_id(uses_rt_id), .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .iREN(iREN), .halted(halted), .stall_count(stall_count)
  );

  typedef struct packed {
    logic       rst, ihit, dhit, dmem, halt, mtr;
    logic [4:0] rd, rs, rt;
    logic       urt, bt;
  } stim_t;

  typedef struct {
    logic [8:0] o;
    int         cnt;
    int         ph;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   phase = 0;

  // Reference state: halted, waiting on a data access, and lost-cycle tally (-1 = unknown).
  bit   m_halt = 1'b0;
  bit   m_pend = 1'b0;
  int   m_cnt  = -1;

  logic [8:0] act;
  assign act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, iREN, halted};

  task automatic step(input stim_t s);
    exp_t e;
    bit   adv, lu, hold;
    @(posedge CLK);
    #1;
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; dmem_req_mem = s.dmem; halt_mem = s.halt;
    memtoreg_ex = s.mtr; rd_ex = s.rd; rs_id = s.rs; rt_id = s.rt;
    uses_rt_id = s.urt; branch_taken = s.bt;

    lu   = s.mtr && (s.rd != 0) && ((s.rd == s.rs) || (s.urt && (s.rd == s.rt)));
    hold = lu && !s.bt;
    if (s.rst || m_halt) adv = 1'b0;
    else if (m_pend)     adv = s.dhit;
    else                 adv = s.dmem ? s.dhit : s.ihit;

    e.cnt = m_cnt;
    e.ph  = phase;
    if (s.rst) e.o = '0;
    else e.o = {adv && !hold, adv && !hold, adv, adv, adv, adv && s.bt, adv && (s.bt || lu),
                !m_halt && !m_pend && !s.dmem, m_halt};
    q.push_back(e);

    if (s.rst) begin
      m_halt = 1'b0; m_pend = 1'b0; m_cnt = 0;
    end else if (!m_halt) begin
      if ((!adv || hold) && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (s.halt && adv) begin
        m_halt = 1'b1; m_pend = 1'b0;
      end else begin
        m_pend = m_pend ? !s.dhit : (s.dmem && !s.dhit);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (act !== e.o) begin
          n_bad++;
          $display("FAIL outputs phase %0d t=%0t: got %b expected %b (pc,ifid,idex,exmem,memwb,ifl,idfl,iren,halted)",
                   e.ph, $time, act, e.o);
        end
        if (e.cnt >= 0) begin
          n_cmp++;
          if (stall_count !== e.cnt[CW-1:0]) begin
            n_bad++;
            $display("FAIL stall_count phase %0d t=%0t: got %0d expected %0d", e.ph, $time, stall_count, e.cnt);
          end
        end
      end
    end
  end

  initial begin : driver
    stim_t s;
    RST = 1'b1; ihit = 0; dhit = 0; dmem_req_mem = 0; halt_mem = 0; memtoreg_ex = 0;
    rd_ex = 0; rs_id = 0; rt_id = 0; uses_rt_id = 0; branch_taken = 0;

    // Reset with every input high, then a plain fetch.
    phase = 1;
    s = '1; step(s); step(s);
    s = '0; s.ihit = 1; step(s);

    // Data miss for three cycles, then hit.
    phase = 2;
    s = '0; s.dmem = 1; s.ihit = 1;
    repeat (3) step(s);
    s.dhit = 1; step(s);
    s = '0; s.ihit = 1; step(s);

    // Load-use on rs, then with rd_ex = 0.
    phase = 3;
    s = '0; s.ihit = 1; s.mtr = 1; s.rd = 8; s.rs = 8; step(s);
    s.rd = 0; s.rs = 0; step(s);
    s = '0; s.ihit = 1; s.mtr = 1; s.rd = 5; s.rt = 5; s.urt = 1; step(s);
    s.urt = 0; step(s);

    // Load-use coinciding with a taken branch.
    phase = 4;
    s = '0; s.ihit = 1; s.mtr = 1; s.rd = 8; s.rs = 8; s.bt = 1; step(s);

    // Halt (with a branch flush in the same cycle), sticky through noise, then reset.
    phase = 5;
    s = '0; s.ihit = 1; s.halt = 1; s.bt = 1; step(s);
    repeat (10) begin
      s = '0; s.ihit = 1'($urandom); s.dhit = 1'($urandom); s.dmem = 1'($urandom); s.halt = 1'($urandom);
      step(s);
    end
    s = '0; s.rst = 1; step(s);
    s = '0; s.ihit = 1; step(s);

    // Counter saturation, then reset in the middle of a data wait.
    phase = 6;
    s = '0;
    repeat (CMAX + 4) step(s);
    s.dmem = 1; step(s); step(s);
    s = '0; s.rst = 1; s.dmem = 1; step(s);
    s = '0; s.ihit = 1; step(s);
    s = '0; step(s);

    // Randomized traffic with small register indices so hazards are frequent.
    phase = 7;
    repeat (600) begin
      s.rst  = ($urandom_range(0, 39) == 0);
      s.ihit = ($urandom_range(0, 9) < 7);
      s.dhit = 1'($urandom);
      s.dmem = ($urandom_range(0, 9) < 3);
      s.halt = ($urandom_range(0, 29) == 0);
      s.mtr  = ($urandom_range(0, 9) < 3);
      s.rd   = 5'($urandom_range(0, 3));
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.urt  = 1'($urandom);
      s.bt   = ($urandom_range(0, 99) < 15);
      step(s);
    end

    repeat (3) @(posedge CLK);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
